addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Two-port round-robin arbiter and sequencer for the shared 8-bit add/sub datapath. It accepts operation requests from two requesters over valid/ready, decodes the 4-bit opcode and drives one operation at a time into the datapath. It waits the datapath's fixed latency, captures sum/carry, and returns a tagged response. It sits between the instruction-decode side and the add/sub unit, and is the only driver of the datapath's operand and control inputs.

## Interface
- `W`, default 8: operand/result width.
- `LAT`, default 2: cycles from ISSUE until `dp_sum`/`dp_cout` are valid; legal range 1..15.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 has an operation.
- `req0_ready` output 1: requester 0's operation is accepted this cycle.
- `req0_op` input 4: requester 0 opcode.
- `req0_a`, `req0_b` input W: requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as above, for requester 1.
- `dp_a`, `dp_b` output W: datapath operands.
- `dp_ctrl` output 4: datapath opcode; 0 = no operation.
- `dp_sub` output 1: 1 for subtract opcodes.
- `dp_sum` input W: datapath result.
- `dp_cout` input 1: datapath carry-out.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: consumer takes the response.
- `rsp_id` output 1: requester index of the response.
- `rsp_sum` output W: captured result.
- `rsp_cout` output 1: captured carry.
- `rsp_err` output 1: illegal opcode; nothing was issued.
- `op_count` output 16: number of legal operations completed, wraps at 0xFFFF→0.

## Operation
- Opcode decode:
  - add = 2, 5, 7 (`dp_sub`=0).
  - sub = 3, 6, 9 (`dp_sub`=1).
  - All other codes are illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester: assert its `reqN_ready` combinationally in this cycle, latch op/a/b/id, and go to ISSUE (legal opcode) or RESP with err (illegal opcode).
  - Both `ready` outputs are 0 in every other state.
- **Arbitration**
  - Round-robin pointer `last`. If both requesters are valid, grant the one with `!last`. If only one is valid, grant it.
  - `last` updates to the granted id on each grant, including illegal-opcode grants.
  - Reset value of `last` = 1, so req0 wins the first contention.
- **ISSUE** (1 cycle): drive `dp_a`/`dp_b`/`dp_ctrl`/`dp_sub` from latched values, load wait counter = LAT, go to WAIT.
- **WAIT**
  - Hold the `dp_*` outputs and decrement the counter.
  - When the counter reaches 1, capture `dp_sum`/`dp_cout` into `rsp_sum`/`rsp_cout`, increment `op_count`, and go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_*` stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - Illegal-opcode response: `rsp_err`=1, `rsp_sum`=0, `rsp_cout`=0; `op_count` unchanged.
- `dp_ctrl`=0, `dp_sub`=0, and `dp_a`=`dp_b`=0 in IDLE and RESP.
- Requests arriving while busy are not accepted. Requesters hold `valid` and data stable until `ready`; the arbiter never drops a held request.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, all outputs 0 (`req*_ready`=0 since no valid is sampled under reset), `rsp_*`=0, `op_count`=0, `last`=1.
- Legal op accepted at cycle T:
  - ISSUE at T+1.
  - WAIT during T+2..T+1+LAT.
  - `rsp_valid` high from T+2+LAT.
  - Minimum accept-to-accept spacing with `rsp_ready` held high: LAT+3 cycles.
- Illegal op accepted at T: `rsp_valid` at T+1; minimum spacing is 2 cycles.
- `rsp_ready` high in the same cycle `rsp_valid` first rises: the response completes that cycle and IDLE is entered at the next edge.
- A request and a response handshake in the same cycle is impossible: grants happen only in IDLE.
- Reset mid-operation aborts any in-flight op. `dp_ctrl` drops to 0 immediately, the response is lost, and no `op_count` increment occurs.

## Test plan
- req0 op=2, a=0x35, b=0x0A, LAT=2, `rsp_ready`=1:
  - `req0_ready` at T; `dp_ctrl`=2 during T+1..T+3.
  - `rsp_valid` at T+4 with id=0, sum=0x3F, cout=0, err=0; `op_count`=1.
- req1 op=3, a=0x05, b=0x07 → `dp_sub`=1; response sum=0xFE, cout=0, id=1. Also a=0x07, b=0x05 → sum=0x02, cout=1.
- Both valid continuously for 4 operations starting from reset → grant order 0,1,0,1; `rsp_id` sequence 0,1,0,1.
- req0 op=4 (illegal) → `rsp_valid` at T+1 with err=1, sum=0; `dp_ctrl` stays 0 throughout; `op_count` unchanged.
- `rsp_ready`=0 for 5 cycles after `rsp_valid` rises → `rsp_*` stable, both `ready` outputs stay 0; release → IDLE the next cycle and the pending req1 is granted.
- Assert `rst_n`=0 during WAIT → all outputs 0 immediately; after release, a new req0 op=7, a=0xFF, b=0x01 → sum=0x00, cout=1, `op_count`=1.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one add/sub datapath.
// Grants in IDLE, issues one op, waits LAT cycles, then returns a tagged response.
module addsub_arbiter #(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic [3:0]   dp_ctrl,
  output logic         dp_sub,
  input  logic [W-1:0] dp_sum,
  input  logic         dp_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_err,
  output logic [15:0]  op_count
);

  localparam int unsigned OPW  = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned CNTW = 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_id;
  logic             r_sub;
  logic             r_err;
  logic             r_cout;
  logic [OPW-1:0]   r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic [CW-1:0]    r_cnt;
  logic [CNTW-1:0]  r_op_count;

  logic             w_gnt;
  logic             w_gnt_id;
  logic [OPW-1:0]   w_sel_op;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic [1:0]       w_dec;
  logic             w_capture;

  // Decode returns {legal, subtract}
  function automatic logic [1:0] f_decode(input logic [OPW-1:0] op);
    case (op)
      4'd2, 4'd5, 4'd7: f_decode = 2'b10;
      4'd3, 4'd6, 4'd9: f_decode = 2'b11;
      default:          f_decode = 2'b00;
    endcase
  endfunction

  // Contention goes to the requester that did not win last time
  assign w_gnt_id  = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_gnt     = (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign w_sel_op  = w_gnt_id ? req1_op : req0_op;
  assign w_sel_a   = w_gnt_id ? req1_a  : req0_a;
  assign w_sel_b   = w_gnt_id ? req1_b  : req0_b;
  assign w_dec     = f_decode(w_sel_op);
  assign w_capture = (r_state == S_WAIT) && (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt) w_next = w_dec[1] ? S_ISSUE : S_RESP;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_capture) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    dp_a       = '0;
    dp_b       = '0;
    dp_ctrl    = '0;
    dp_sub     = 1'b0;
    rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = w_gnt && !w_gnt_id;
        req1_ready = w_gnt && w_gnt_id;
      end
      S_ISSUE, S_WAIT: begin
        dp_a    = r_a;
        dp_b    = r_b;
        dp_ctrl = r_op;
        dp_sub  = r_sub;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch, latency counter, result capture and completion count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_id       <= 1'b0;
      r_sub      <= 1'b0;
      r_err      <= 1'b0;
      r_cout     <= 1'b0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_op_count <= '0;
    end else begin
      if (w_gnt) begin
        r_last <= w_gnt_id;
        r_id   <= w_gnt_id;
        r_op   <= w_sel_op;
        r_a    <= w_sel_a;
        r_b    <= w_sel_b;
        r_sub  <= w_dec[0];
        r_err  <= ~w_dec[1];
        r_sum  <= '0;
        r_cout <= 1'b0;
      end
      if (r_state == S_ISSUE) r_cnt <= CW'(LAT);
      if (r_state == S_WAIT)  r_cnt <= r_cnt - CW'(1);
      if (w_capture) begin
        r_sum      <= dp_sum;
        r_cout     <= dp_cout;
        r_op_count <= r_op_count + CNTW'(1);
      end
    end
  end

  assign rsp_id   = r_id;
  assign rsp_sum  = r_sum;
  assign rsp_cout = r_cout;
  assign rsp_err  = r_err;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a LAT-deep pipelined add/sub datapath model.
module tb_addsub_arbiter;

  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 2;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [3:0]   req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [3:0]   req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic [W-1:0] dp_a, dp_b;
  logic [3:0]   dp_ctrl;
  logic         dp_sub;
  logic [W-1:0] dp_sum;
  logic         dp_cout;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err;
  logic [W-1:0] rsp_sum;
  logic [15:0]  op_count;

  int n_run;
  int n_fail;

  addsub_arbiter #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .dp_a(dp_a), .dp_b(dp_b), .dp_ctrl(dp_ctrl), .dp_sub(dp_sub),
    .dp_sum(dp_sum), .dp_cout(dp_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath model: result valid exactly LAT cycles after the operands appear
  logic [8:0] pipe [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= dp_sub ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 9'd1) : ({1'b0, dp_a} + {1'b0, dp_b});
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign dp_sum  = pipe[LAT-1][7:0];
  assign dp_cout = pipe[LAT-1][8];

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    chk("rsp_timeout", rsp_valid, 1);
  endtask

  // Issue one request and return in the first cycle rsp_valid is high
  task automatic run_op(input bit id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic sub1, output logic [3:0] ctrl_or);
    int acc;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    acc = 0;
    while (!(id ? req1_ready : req0_ready) && acc < 20) begin
      @(negedge clk); #1;
      acc++;
    end
    chk("accept_timeout", id ? req1_ready : req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    sub1    = dp_sub;
    ctrl_or = dp_ctrl;
    lat     = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); #1;
      ctrl_or |= dp_ctrl;
      lat++;
    end
    chk("rsp_timeout", rsp_valid, 1);
  endtask

  int         lat;
  logic       sub1;
  logic [3:0] ctrl_or;
  int         gnt_id [4];
  int         gnt_cyc [4];
  int         rsp_ids [4];
  logic [7:0] rsp_sums [4];
  int         ng, nr;

  initial begin
    n_run = 0; n_fail = 0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_dp_ctrl", dp_ctrl, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // req0 add 0x35+0x0A, cycle-by-cycle timing
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 8'h35; req0_b = 8'h0A;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("t1_issue_ctrl", dp_ctrl, 2);
    chk("t1_issue_a", dp_a, 8'h35);
    chk("t1_issue_b", dp_b, 8'h0A);
    chk("t1_issue_sub", dp_sub, 0);
    @(negedge clk); #1;
    chk("t1_wait1_ctrl", dp_ctrl, 2);
    @(negedge clk); #1;
    chk("t1_wait2_ctrl", dp_ctrl, 2);
    chk("t1_wait2_rsp_valid", rsp_valid, 0);
    @(negedge clk); #1;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_sum", rsp_sum, 8'h3F);
    chk("t1_rsp_cout", rsp_cout, 0);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_op_count", op_count, 1);
    chk("t1_resp_ctrl", dp_ctrl, 0);
    @(negedge clk); #1;
    chk("t1_idle_rsp_valid", rsp_valid, 0);

    // req1 subtract, borrow and no-borrow
    run_op(1'b1, 4'd3, 8'h05, 8'h07, lat, sub1, ctrl_or);
    chk("t2a_sub", sub1, 1);
    chk("t2a_lat", lat, LAT + 2);
    chk("t2a_sum", rsp_sum, 8'hFE);
    chk("t2a_cout", rsp_cout, 0);
    chk("t2a_id", rsp_id, 1);
    run_op(1'b1, 4'd3, 8'h07, 8'h05, lat, sub1, ctrl_or);
    chk("t2b_sum", rsp_sum, 8'h02);
    chk("t2b_cout", rsp_cout, 1);
    chk("t2b_op_count", op_count, 3);

    // Illegal opcode
    run_op(1'b0, 4'd4, 8'h12, 8'h34, lat, sub1, ctrl_or);
    chk("ill_lat", lat, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_sum", rsp_sum, 0);
    chk("ill_cout", rsp_cout, 0);
    chk("ill_ctrl", ctrl_or, 0);
    chk("ill_op_count", op_count, 3);

    // Continuous contention from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin gnt_id[i] = -1; gnt_cyc[i] = -1; rsp_ids[i] = -1; rsp_sums[i] = 8'hxx; end
    ng = 0; nr = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 8'h01; req0_b = 8'h01;
    req1_valid = 1'b1; req1_op = 4'd9; req1_a = 8'h10; req1_b = 8'h01;
    #1;
    for (int k = 0; k < 60 && nr < 4; k++) begin
      if ((req0_ready || req1_ready) && ng < 4) begin
        gnt_id[ng] = req1_ready ? 1 : 0; gnt_cyc[ng] = k; ng++;
      end
      if (rsp_valid) begin
        rsp_ids[nr] = int'(rsp_id); rsp_sums[nr] = rsp_sum; nr++;
      end
      if (nr < 4) begin @(negedge clk); #1; end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_gnt0", gnt_id[0], 0);
    chk("rr_gnt1", gnt_id[1], 1);
    chk("rr_gnt2", gnt_id[2], 0);
    chk("rr_gnt3", gnt_id[3], 1);
    chk("rr_rsp_id0", rsp_ids[0], 0);
    chk("rr_rsp_id1", rsp_ids[1], 1);
    chk("rr_rsp_id2", rsp_ids[2], 0);
    chk("rr_rsp_id3", rsp_ids[3], 1);
    chk("rr_sum0", rsp_sums[0], 8'h02);
    chk("rr_sum1", rsp_sums[1], 8'h0F);
    chk("rr_spacing", gnt_cyc[1] - gnt_cyc[0], LAT + 3);
    chk("rr_op_count", op_count, 4);

    // Response back-pressure with a pending req1
    rsp_ready = 1'b0;
    run_op(1'b0, 4'd2, 8'h11, 8'h22, lat, sub1, ctrl_or);
    req1_valid = 1'b1; req1_op = 4'd6; req1_a = 8'h30; req1_b = 8'h10;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_sum", rsp_sum, 8'h33);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      if (k < 4) begin @(negedge clk); #1; end
    end
    chk("bp_op_count", op_count, 5);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", rsp_valid, 1);
    chk("bp_release_ready1", req1_ready, 0);
    @(negedge clk); #1;
    chk("bp_idle_ready1", req1_ready, 1);
    chk("bp_idle_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    wait_rsp(lat);
    chk("bp_r1_sum", rsp_sum, 8'h20);
    chk("bp_r1_cout", rsp_cout, 1);
    chk("bp_r1_id", rsp_id, 1);
    chk("bp_r1_op_count", op_count, 6);

    // Reset during WAIT aborts the op
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 8'h11; req0_b = 8'h11;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    chk("mr_wait_ctrl", dp_ctrl, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_ctrl", dp_ctrl, 0);
    chk("mr_dp_a", dp_a, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_op_count", op_count, 0);
    chk("mr_rsp_sum", rsp_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("mr_lost_rsp", rsp_valid, 0);
    end
    run_op(1'b0, 4'd7, 8'hFF, 8'h01, lat, sub1, ctrl_or);
    chk("mr_sum", rsp_sum, 8'h00);
    chk("mr_cout", rsp_cout, 1);
    chk("mr_id", rsp_id, 0);
    chk("mr_new_op_count", op_count, 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
